// File: rtl/ct_sequencer.sv
// ct_sequencer: plays a 16-entry table of (CMPR0 value, duration) pairs into
// the counter/timer CMPR0 register, advancing on the timer's top_flag.
// It shares the timer register port with the CPU; CPU accesses always win.
//
// Build option: define CT_SEQ_LOOP_EN to implement the CTRL LOOP bit.
// Without it, CTRL bit 2 is ignored and reads 0, and a sequence always ends
// in IDLE with DONE set after its last entry.
//
// Register map (offsets from SEQ_ADDRESS):
//   +0 CTRL   {4'b0, IRQ_EN, LOOP, STOP, START}  (START/STOP self-clearing)
//   +1 STATUS {IDX[3:0], 2'b0, DONE, BUSY}        (DONE clears when read)
//   +2 LEN    number of entries, 0 means 16
//   +3 PTR    table byte pointer
//   +4 DATA   table[PTR]; writes post-increment PTR modulo 32
module ct_sequencer #(
    parameter logic [7:0] SEQ_ADDRESS = 8'h08,
    parameter logic [7:0] CT_ADDRESS  = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] din,
    input  logic [7:0] address,
    input  logic       w_en,
    input  logic       r_en,
    output logic [7:0] dout,
    output logic [7:0] ct_address,
    output logic [7:0] ct_din,
    output logic       ct_w_en,
    output logic       ct_r_en,
    input  logic       top_flag,
    output logic       done_flag
);

    localparam logic [7:0] CMPR0_ADDRESS = CT_ADDRESS + 8'd3;

    localparam logic [2:0] OFF_CTRL   = 3'd0;
    localparam logic [2:0] OFF_STATUS = 3'd1;
    localparam logic [2:0] OFF_LEN    = 3'd2;
    localparam logic [2:0] OFF_PTR    = 3'd3;
    localparam logic [2:0] OFF_DATA   = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_ADVANCE
    } state_t;

    state_t     state_reg;
    logic [3:0] idx_reg;
    logic       busy_reg;
    logic       done_reg;
    logic [7:0] pc_reg;
    logic [7:0] dur_reg;
    logic       done_flag_reg;

    logic [3:0] len_reg;
    logic [4:0] ptr_reg;
    logic       irq_en_reg;
    logic [7:0] dout_reg;
`ifdef CT_SEQ_LOOP_EN
    logic       loop_reg;
`endif
    logic       loop_bit;

    // 32-byte pattern table; deliberately left without reset.
    logic [7:0] tbl_mem [0:31];

    // Address decode. Offsets are computed by subtraction so that window
    // checks are a single unsigned compare regardless of the base address.
    logic [7:0] seq_off;
    logic [7:0] ct_off;
    logic       seq_hit;
    logic       ct_hit;
    logic       cpu_ct;
    logic       seq_we;
    logic       seq_re;
    logic       ctrl_we;
    logic       start_cmd;
    logic       stop_cmd;
    logic       status_re;
    logic       data_we;
    logic       seq_load_wr;
    logic       last_entry;
    logic [7:0] cmpr_val;
    logic [7:0] dur_val;
    logic [7:0] rd_data;

    assign seq_off   = address - SEQ_ADDRESS;
    assign ct_off    = address - CT_ADDRESS;
    assign seq_hit   = (seq_off < 8'd5);
    assign ct_hit    = (ct_off < 8'd6);
    assign cpu_ct    = (w_en || r_en) && ct_hit;
    assign seq_we    = w_en && seq_hit;
    assign seq_re    = r_en && seq_hit;
    assign ctrl_we   = seq_we && (seq_off[2:0] == OFF_CTRL);
    assign start_cmd = ctrl_we && din[0];
    assign stop_cmd  = ctrl_we && din[1];
    assign status_re = seq_re && (seq_off[2:0] == OFF_STATUS);
    assign data_we   = seq_we && (seq_off[2:0] == OFF_DATA);

`ifdef CT_SEQ_LOOP_EN
    assign loop_bit = loop_reg;
`else
    assign loop_bit = 1'b0;
`endif

    // Entry i lives at bytes 2i (compare value) and 2i+1 (duration).
    assign cmpr_val   = tbl_mem[{idx_reg, 1'b0}];
    assign dur_val    = tbl_mem[{idx_reg, 1'b1}];
    // LEN of 0 wraps to 15 here, giving a 16-entry sequence.
    assign last_entry = (idx_reg == (len_reg - 4'd1));

    // The sequencer only gets the port in LOAD when the CPU is not using it.
    assign seq_load_wr = (state_reg == ST_LOAD) && !cpu_ct;

    // Timer port mux: CPU pass-through has priority over the CMPR0 update.
    always_comb begin
        ct_address = CMPR0_ADDRESS;
        ct_din     = 8'h00;
        ct_w_en    = 1'b0;
        ct_r_en    = 1'b0;
        if (cpu_ct) begin
            ct_address = address;
            ct_din     = din;
            ct_w_en    = w_en;
            ct_r_en    = r_en;
        end else if (seq_load_wr) begin
            ct_din  = cmpr_val;
            ct_w_en = 1'b1;
        end
    end

    // Read-data selection for the sequencer register window.
    always_comb begin
        rd_data = 8'h00;
        case (seq_off[2:0])
            OFF_CTRL:   rd_data = {4'b0000, irq_en_reg, loop_bit, 2'b00};
            OFF_STATUS: rd_data = {idx_reg, 2'b00, done_reg, busy_reg};
            OFF_LEN:    rd_data = {4'b0000, len_reg};
            OFF_PTR:    rd_data = {3'b000, ptr_reg};
            OFF_DATA:   rd_data = tbl_mem[ptr_reg];
            default:    rd_data = 8'h00;
        endcase
    end

    // Table RAM write port (CPU DATA writes only).
    always_ff @(posedge clk) begin
        if (data_we) begin
            tbl_mem[ptr_reg] <= din;
        end
    end

    // CPU-visible configuration registers and the registered read port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_reg    <= 4'd0;
            ptr_reg    <= 5'd0;
            irq_en_reg <= 1'b0;
            dout_reg   <= 8'h00;
`ifdef CT_SEQ_LOOP_EN
            loop_reg   <= 1'b0;
`endif
        end else begin
            if (r_en) begin
                dout_reg <= seq_hit ? rd_data : 8'h00;
            end
            if (seq_we) begin
                case (seq_off[2:0])
                    OFF_CTRL: begin
                        irq_en_reg <= din[3];
`ifdef CT_SEQ_LOOP_EN
                        loop_reg   <= din[2];
`endif
                    end
                    OFF_LEN:  len_reg <= din[3:0];
                    OFF_PTR:  ptr_reg <= din[4:0];
                    OFF_DATA: ptr_reg <= ptr_reg + 5'd1;
                    default:  ;
                endcase
            end
        end
    end

    // Sequencer FSM: IDLE -> LOAD -> RUN -> ADVANCE -> (LOAD | IDLE).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= ST_IDLE;
            idx_reg       <= 4'd0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            pc_reg        <= 8'd0;
            dur_reg       <= 8'd0;
            done_flag_reg <= 1'b0;
        end else begin
            done_flag_reg <= 1'b0;
            // Reading STATUS clears DONE; a completion in the same cycle
            // overrides this below so the event is not lost.
            if (status_re) begin
                done_reg <= 1'b0;
            end
            if (stop_cmd) begin
                state_reg <= ST_IDLE;
                busy_reg  <= 1'b0;
                idx_reg   <= 4'd0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (start_cmd) begin
                            state_reg <= ST_LOAD;
                            idx_reg   <= 4'd0;
                            busy_reg  <= 1'b1;
                            done_reg  <= 1'b0;
                        end
                    end
                    ST_LOAD: begin
                        // Duration is captured here so later table edits
                        // only affect entries that have not yet been loaded.
                        if (!cpu_ct) begin
                            pc_reg    <= 8'd0;
                            dur_reg   <= dur_val;
                            state_reg <= ST_RUN;
                        end
                    end
                    ST_RUN: begin
                        // Duration 0 compares against 255, i.e. 256 periods.
                        if (top_flag) begin
                            pc_reg <= pc_reg + 8'd1;
                            if (pc_reg == (dur_reg - 8'd1)) begin
                                state_reg <= ST_ADVANCE;
                            end
                        end
                    end
                    ST_ADVANCE: begin
                        if (last_entry) begin
                            if (loop_bit) begin
                                idx_reg   <= 4'd0;
                                state_reg <= ST_LOAD;
                            end else begin
                                idx_reg       <= 4'd0;
                                state_reg     <= ST_IDLE;
                                busy_reg      <= 1'b0;
                                done_reg      <= 1'b1;
                                done_flag_reg <= irq_en_reg;
                            end
                        end else begin
                            idx_reg   <= idx_reg + 4'd1;
                            state_reg <= ST_LOAD;
                        end
                    end
                    default: begin
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign dout      = dout_reg;
    assign done_flag = done_flag_reg;

endmodule

// File: tb/tb_ct_sequencer.sv
// Testbench for ct_sequencer: directed scenarios plus randomized register
// traffic, all checked every cycle against a transaction-level model.
module tb_ct_sequencer;

    localparam logic [7:0] SEQ = 8'h08;
    localparam logic [7:0] CT  = 8'h00;
`ifdef CT_SEQ_LOOP_EN
    localparam bit LOOP_EN = 1'b1;
`else
    localparam bit LOOP_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] din = 8'h00;
    logic [7:0] address = 8'h00;
    logic       w_en = 1'b0;
    logic       r_en = 1'b0;
    logic       top_flag = 1'b0;
    logic [7:0] dout;
    logic [7:0] ct_address;
    logic [7:0] ct_din;
    logic       ct_w_en;
    logic       ct_r_en;
    logic       done_flag;

    ct_sequencer #(.SEQ_ADDRESS(SEQ), .CT_ADDRESS(CT)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .address    (address),
        .w_en       (w_en),
        .r_en       (r_en),
        .dout       (dout),
        .ct_address (ct_address),
        .ct_din     (ct_din),
        .ct_w_en    (ct_w_en),
        .ct_r_en    (ct_r_en),
        .top_flag   (top_flag),
        .done_flag  (done_flag)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Sequence progress is tracked as "waiting to load", "periods remaining"
    // and "entry finished" rather than a counter compare.
    bit         m_busy, m_done, m_pend, m_adv, m_loop, m_irq, m_dflag;
    int         m_idx, m_len, m_ptr, m_rem;
    logic [7:0] m_tbl [32];
    logic [7:0] m_dout;
    int         mo_so, mo_co, mo_last, mo_d;
    bit         mo_cpu, mo_start, mo_stop, mo_setdone;
    logic [7:0] mo_rd;

    initial for (int i = 0; i < 32; i++) m_tbl[i] = 8'h00;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy = 0; m_done = 0; m_pend = 0; m_adv = 0; m_loop = 0; m_irq = 0;
            m_dflag = 0; m_idx = 0; m_len = 0; m_ptr = 0; m_rem = 0; m_dout = 8'h00;
        end else begin
            mo_so    = int'(address) - int'(SEQ);
            mo_co    = int'(address) - int'(CT);
            mo_cpu   = (w_en || r_en) && mo_co >= 0 && mo_co <= 5;
            mo_start = w_en && mo_so == 0 && din[0];
            mo_stop  = w_en && mo_so == 0 && din[1];
            // read port sees pre-update state
            if (r_en) begin
                mo_rd = 8'h00;
                if (mo_so == 0) begin mo_rd[3] = m_irq; mo_rd[2] = LOOP_EN && m_loop; end
                else if (mo_so == 1) mo_rd = {m_idx[3:0], 2'b00, m_done, m_busy};
                else if (mo_so == 2) mo_rd = {4'b0000, m_len[3:0]};
                else if (mo_so == 3) mo_rd = {3'b000, m_ptr[4:0]};
                else if (mo_so == 4) mo_rd = m_tbl[m_ptr];
                m_dout = mo_rd;
            end
            m_dflag = 0;
            mo_setdone = 0;
            mo_last = ((m_len == 0) ? 16 : m_len) - 1;
            if (mo_stop) begin
                m_busy = 0; m_pend = 0; m_adv = 0; m_idx = 0;
            end else if (!m_busy) begin
                if (mo_start) begin m_busy = 1; m_idx = 0; m_done = 0; m_pend = 1; end
            end else if (m_pend) begin
                if (!mo_cpu) begin
                    m_pend = 0;
                    mo_d = int'(m_tbl[2*m_idx+1]);
                    m_rem = (mo_d == 0) ? 256 : mo_d;
                end
            end else if (m_adv) begin
                m_adv = 0;
                if (m_idx == mo_last) begin
                    if (LOOP_EN && m_loop) begin
                        m_idx = 0; m_pend = 1;
                    end else begin
                        m_busy = 0; m_done = 1; mo_setdone = 1; m_dflag = m_irq; m_idx = 0;
                    end
                end else begin
                    m_idx = m_idx + 1; m_pend = 1;
                end
            end else if (top_flag) begin
                m_rem = m_rem - 1;
                if (m_rem == 0) m_adv = 1;
            end
            if (r_en && mo_so == 1 && !mo_setdone) m_done = 0;
            if (w_en) begin
                if (mo_so == 0) begin m_irq = din[3]; m_loop = din[2]; end
                else if (mo_so == 2) m_len = int'(din[3:0]);
                else if (mo_so == 3) m_ptr = int'(din[4:0]);
                else if (mo_so == 4) begin m_tbl[m_ptr] = din; m_ptr = (m_ptr + 1) % 32; end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [7:0] seqw [$];
    int         dcount = 0;
    int         c_co;
    bit         c_cpu, e_w, e_r;
    logic [7:0] e_addr, e_din;

    always @(negedge clk) begin
        c_co  = int'(address) - int'(CT);
        c_cpu = (w_en || r_en) && c_co >= 0 && c_co <= 5;
        if (c_cpu) begin
            e_w = w_en; e_r = r_en; e_addr = address; e_din = din;
        end else if (m_busy && m_pend) begin
            e_w = 1; e_r = 0; e_addr = CT + 8'd3; e_din = m_tbl[2*m_idx];
        end else begin
            e_w = 0; e_r = 0; e_addr = 8'h00; e_din = 8'h00;
        end
        chk("ct_w_en", ct_w_en, e_w);
        chk("ct_r_en", ct_r_en, e_r);
        if (e_w) begin
            chk("ct_address", ct_address, e_addr);
            chk("ct_din", ct_din, e_din);
        end
        chk("done_flag", done_flag, m_dflag);
        chk("dout", dout, m_dout);
        if (!c_cpu && ct_w_en === 1'b1 && ct_address === CT + 8'd3) seqw.push_back(ct_din);
        if (done_flag === 1'b1) dcount++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        address = a; din = d; w_en = 1'b1;
        @(posedge clk); #1;
        w_en = 1'b0; address = 8'h00; din = 8'h00;
    endtask

    task automatic rd(input logic [7:0] a);
        address = a; r_en = 1'b1;
        @(posedge clk); #1;
        r_en = 1'b0; address = 8'h00;
    endtask

    // one top_flag pulse followed by enough quiet cycles to cross LOAD
    task automatic pulse_slow();
        top_flag = 1'b1; @(posedge clk); #1; top_flag = 1'b0;
        idle(3);
    endtask

    task automatic pulse_fast();
        top_flag = 1'b1; @(posedge clk); #1; top_flag = 1'b0;
        idle(1);
    endtask

    task automatic clear_log();
        seqw.delete();
        dcount = 0;
    endtask

    int         op;
    logic [7:0] rdin;

    initial begin
        #12;
        chk("reset_dout", dout, 8'h00);
        chk("reset_done_flag", done_flag, 1'b0);
        chk("reset_ct_w_en", ct_w_en, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        idle(2);
        rd(SEQ + 8'd1);
        chk("reset_status", dout, 8'h00);

        // clear the whole table
        wr(SEQ + 8'd3, 8'd0);
        for (int i = 0; i < 32; i++) wr(SEQ + 8'd4, 8'h00);

        // Scenario 1: two entries, IRQ on
        clear_log();
        wr(SEQ + 8'd3, 8'd0);
        wr(SEQ + 8'd4, 8'h40); wr(SEQ + 8'd4, 8'd3);
        wr(SEQ + 8'd4, 8'hC0); wr(SEQ + 8'd4, 8'd1);
        wr(SEQ + 8'd2, 8'd2);
        wr(SEQ + 8'd0, 8'h08);
        wr(SEQ + 8'd0, 8'h09);
        idle(3);
        pulse_slow(); pulse_slow(); pulse_slow();
        top_flag = 1'b1; @(posedge clk); #1; top_flag = 1'b0;
        chk("s1_flag_before", done_flag, 1'b0);
        @(posedge clk); #1;
        chk("s1_flag_pulse", done_flag, 1'b1);
        @(posedge clk); #1;
        chk("s1_flag_after", done_flag, 1'b0);
        idle(2);
        chk("s1_nwrites", seqw.size(), 2);
        if (seqw.size() == 2) begin
            chk("s1_write0", seqw[0], 8'h40);
            chk("s1_write1", seqw[1], 8'hC0);
        end
        chk("s1_done_pulses", dcount, 1);
        rd(SEQ + 8'd1);
        chk("s1_status_done", dout, 8'h02);
        rd(SEQ + 8'd1);
        chk("s1_status_clear", dout, 8'h00);

        // Scenario 2: duration 0 means 256 periods
        clear_log();
        wr(SEQ + 8'd3, 8'd0);
        wr(SEQ + 8'd4, 8'h55); wr(SEQ + 8'd4, 8'd0);
        wr(SEQ + 8'd2, 8'd1);
        wr(SEQ + 8'd0, 8'h09);
        idle(3);
        repeat (255) pulse_fast();
        rd(SEQ + 8'd1);
        chk("s2_status_255", dout, 8'h01);
        pulse_fast();
        idle(2);
        rd(SEQ + 8'd1);
        chk("s2_status_256", dout, 8'h02);
        chk("s2_done_pulses", dcount, 1);

        // Scenario 3: CPU timer write collides with LOAD
        clear_log();
        wr(SEQ + 8'd3, 8'd0);
        wr(SEQ + 8'd4, 8'h11); wr(SEQ + 8'd4, 8'd1);
        wr(SEQ + 8'd0, 8'h01);
        address = CT + 8'd2; din = 8'h05; w_en = 1'b1;
        #1;
        chk("s3_cpu_addr", ct_address, 8'h02);
        chk("s3_cpu_din", ct_din, 8'h05);
        chk("s3_cpu_wen", ct_w_en, 1'b1);
        @(posedge clk); #1;
        w_en = 1'b0; address = 8'h00; din = 8'h00;
        #1;
        chk("s3_seq_addr", ct_address, 8'h03);
        chk("s3_seq_din", ct_din, 8'h11);
        chk("s3_seq_wen", ct_w_en, 1'b1);
        @(posedge clk); #1;
        wr(SEQ + 8'd0, 8'h02);
        idle(2);

        // Scenario 4: LOOP behaviour
        clear_log();
        wr(SEQ + 8'd3, 8'd0);
        wr(SEQ + 8'd4, 8'h22); wr(SEQ + 8'd4, 8'd1);
        wr(SEQ + 8'd2, 8'd1);
        wr(SEQ + 8'd0, 8'h0D);
        idle(3);
`ifdef CT_SEQ_LOOP_EN
        rd(SEQ + 8'd0);
        chk("s4_ctrl_loop", dout, 8'h0C);
        pulse_slow(); pulse_slow(); pulse_slow();
        chk("s4_rewrites", seqw.size(), 4);
        chk("s4_no_done", dcount, 0);
        wr(SEQ + 8'd0, 8'h02);
        idle(1);
        rd(SEQ + 8'd1);
        chk("s4_status_stop", dout, 8'h00);
`else
        rd(SEQ + 8'd0);
        chk("s4_ctrl_noloop", dout, 8'h08);
        pulse_slow();
        chk("s4_writes", seqw.size(), 1);
        chk("s4_done", dcount, 1);
        rd(SEQ + 8'd1);
        chk("s4_status", dout, 8'h02);
`endif

        // Scenario 5: PTR wraps modulo 32
        wr(SEQ + 8'd3, 8'd31);
        wr(SEQ + 8'd4, 8'hA1); wr(SEQ + 8'd4, 8'hA2);
        rd(SEQ + 8'd3);
        chk("s5_ptr", dout, 8'h01);
        wr(SEQ + 8'd3, 8'd31);
        rd(SEQ + 8'd4);
        chk("s5_byte31", dout, 8'hA1);
        wr(SEQ + 8'd3, 8'd0);
        rd(SEQ + 8'd4);
        chk("s5_byte0", dout, 8'hA2);
        rd(8'h20);
        chk("s5_other_addr", dout, 8'h00);

        // Randomized traffic with short durations
        wr(SEQ + 8'd3, 8'd0);
        for (int i = 0; i < 32; i++) wr(SEQ + 8'd4, 8'($urandom_range(1, 3)));
        for (int i = 0; i < 3000; i++) begin
            op = $urandom_range(0, 19);
            top_flag = ($urandom_range(0, 3) == 0);
            address = 8'h00; din = 8'h00; w_en = 1'b0; r_en = 1'b0;
            case (op)
                0, 1: begin
                    rdin = 8'($urandom_range(0, 15));
                    if ($urandom_range(0, 3) != 0) rdin[1] = 1'b0;
                    address = SEQ; din = rdin; w_en = 1'b1;
                end
                2, 3: begin address = SEQ + 8'($urandom_range(0, 4)); r_en = 1'b1; end
                4, 5: begin
                    address = CT + 8'($urandom_range(0, 5)); din = 8'($urandom);
                    if ($urandom_range(0, 1) == 0) w_en = 1'b1; else r_en = 1'b1;
                end
                6: begin address = SEQ + 8'd2; din = 8'($urandom_range(0, 3)); w_en = 1'b1; end
                7: begin address = SEQ + 8'd3; din = 8'($urandom_range(0, 31)); w_en = 1'b1; end
                8: begin address = SEQ + 8'd4; din = 8'($urandom_range(1, 3)); w_en = 1'b1; end
                9: begin address = 8'h30; r_en = 1'b1; end
                default: ;
            endcase
            @(posedge clk); #1;
        end
        top_flag = 1'b0; w_en = 1'b0; r_en = 1'b0; address = 8'h00; din = 8'h00;
        idle(2);

        // Scenario 6: asynchronous reset while running
        wr(SEQ + 8'd0, 8'h02);
        wr(SEQ + 8'd3, 8'd0);
        wr(SEQ + 8'd4, 8'h33); wr(SEQ + 8'd4, 8'd5);
        wr(SEQ + 8'd2, 8'd1);
        wr(SEQ + 8'd0, 8'h09);
        idle(3);
        pulse_slow();
        rd(SEQ + 8'd1);
        chk("s6_status_run", dout, 8'h01);
        #2 rst = 1'b0;
        #1;
        chk("s6_rst_dout", dout, 8'h00);
        chk("s6_rst_done_flag", done_flag, 1'b0);
        chk("s6_rst_ct_w_en", ct_w_en, 1'b0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        clear_log();
        idle(5);
        chk("s6_no_writes", seqw.size(), 0);
        rd(SEQ + 8'd1);
        chk("s6_status_idle", dout, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
